// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed hex 7-segment scan driver with anti-ghost blanking and blink
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int GHOST        = 2,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic                    digit_load,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    output logic [6:0]              seg_out,
    output logic                    mask,
    output logic [NUM_DIGITS-1:0]   digit_sel
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [FW-1:0]           frame_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] digit_sh;
    logic [NUM_DIGITS-1:0]   blink_sh;

    function automatic logic [6:0] decode(input logic [3:0] hex);
        case (hex)
            4'h0:    decode = 7'h3F;
            4'h1:    decode = 7'h06;
            4'h2:    decode = 7'h5B;
            4'h3:    decode = 7'h4F;
            4'h4:    decode = 7'h66;
            4'h5:    decode = 7'h6D;
            4'h6:    decode = 7'h7D;
            4'h7:    decode = 7'h07;
            4'h8:    decode = 7'h7F;
            4'h9:    decode = 7'h6F;
            4'hA:    decode = 7'h77;
            4'hB:    decode = 7'h7C;
            4'hC:    decode = 7'h39;
            4'hD:    decode = 7'h5E;
            4'hE:    decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BLANK;
            cnt         <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            digit_sh    <= '0;
            blink_sh    <= '0;
            seg_out     <= '0;
            mask        <= 1'b0;
            digit_sel   <= '0;
        end else begin
            if (digit_load) begin
                digit_sh <= digit_data;
                blink_sh <= blink_en;
            end

            if (cnt == CW'(SCAN_DIV - 1))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            case (state)
                BLANK: begin
                    // seg_out is loaded once here and held, so the digit cannot tear mid-slot
                    if (cnt == CW'(GHOST - 1)) begin
                        state     <= SHOW;
                        digit_sel <= NUM_DIGITS'(1) << idx;
                        seg_out   <= decode(digit_sh[idx*4 +: 4]);
                        mask      <= ~(blink_sh[idx] & blink_phase);
                    end
                end
                SHOW: begin
                    if (cnt == CW'(SCAN_DIV - 1)) begin
                        state     <= BLANK;
                        digit_sel <= '0;
                        seg_out   <= '0;
                        mask      <= 1'b0;
                        if (idx == IW'(NUM_DIGITS - 1)) begin
                            idx <= '0;
                            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                                frame_cnt   <= '0;
                                blink_phase <= ~blink_phase;
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        mask <= ~(blink_sh[idx] & blink_phase);
                    end
                end
                default: state <= BLANK;
            endcase
        end
    end

endmodule
